exec_issue_ctrl: RTL and testbench
==================================

# exec_issue_ctrl

Issue controller between instruction decode and `instruction_execute`. It holds a two-entry skid buffer of decoded instructions with their operands. It sequences them into the execute datapath over a valid/ready handshake, refreshing operands from write-back and stalling on load-use hazards. It discards everything it holds when execute resolves a taken branch or jump.

## Interface
Parameters
- `XLEN`, 32, data/PC width.
- `CNT_W`, 16, width of the hazard-stall counter.

Ports
- `clk`  in  1  single clock; all state updates on rising edge.
- `rstf`  in  1  reset, synchronous, active-low.
- `t_instr`, `t_instr_valid`, `t_instr_ready`  in/in/out  32/1/1  decode-side handshake; beat = one decoded instruction.
- `t_pc`, `t_op`, `t_imm`  in  XLEN/5/XLEN  PC, `operation_t` code, immediate of the beat.
- `t_rs1`, `t_rs2`  in  5/5  source register indices.
- `t_rs1Value`, `t_rs2Value`  in  XLEN  register-file read values.
- `i_instr`, `i_instr_valid`, `i_instr_ready`  out/out/in  32/1/1  execute-side handshake.
- `i_pc`, `i_op`, `i_imm`, `i_rs1Value`, `i_rs2Value`  out  XLEN/5/XLEN/XLEN/XLEN  head-entry fields to execute.
- `ld_valid`, `ld_rd`  in  1/5  a load is in flight in the memory stage, destination `ld_rd`.
- `wb_valid`, `wb_rd`, `wb_value`  in  1/5/XLEN  register write-back this cycle.
- `flush`  in  1  taken branch/jump resolved in execute (`branchTaken` qualified by the execute handshake).
- `stall_count`  out  CNT_W  saturating count of hazard-stall cycles.

## Operation
- Storage: head entry H and skid entry S, each {instr, pc, op, imm, rs1, rs2, rs1Value, rs2Value}.
- States: EMPTY (none valid), ONE (H valid), TWO (H and S valid).
- Accept = `t_instr_valid & t_instr_ready`. Issue = `i_instr_valid & i_instr_ready`.
- `t_instr_ready` = (state != TWO) & `rstf`; it depends only on registered state.
- Transitions:
  - EMPTY→ONE on accept.
  - ONE→EMPTY on issue without accept.
  - ONE→TWO on accept without issue.
  - ONE stays ONE on accept and issue together; the new beat loads H.
  - TWO→ONE on issue, with S moving to H.
- Hazard: `haz` = H valid & `ld_valid` & ((`rs1`≠0 & `rs1`==`ld_rd`) | (`rs2`≠0 & `rs2`==`ld_rd`)).
- `i_instr_valid` = H valid & !`haz` & !`flush`.
- Forwarding: each cycle with `wb_valid` & `wb_rd`≠0, every stored operand whose index equals `wb_rd` is overwritten with `wb_value`. This applies to H, S, and a beat being accepted that cycle.
- `i_rs1Value`/`i_rs2Value` are bypassed combinationally from `wb_value` on a same-cycle match.
- x0 never matches, for either hazard or forwarding.
- Flush: next state EMPTY, H and S invalid. A beat accepted in the flush cycle is discarded. No issue occurs in the flush cycle.
- `stall_count` increments each cycle `haz` & !`flush` is true and saturates at all-ones.
- Arithmetic: index compares are 5-bit equality. No operand arithmetic is performed in this block.

## Timing
- Reset (`rstf` low at a clock edge):
  - state EMPTY; `t_instr_ready` 0 while `rstf` low.
  - `i_instr_valid` 0; all `i_*` data outputs 0; `stall_count` 0.
  - Reset mid-operation drops both entries with no issue.
- Latency: a beat accepted at edge N is presented at `i_instr_valid` after edge N, absent a hazard. Throughput is one instruction per cycle.
- Hazard stall: H is held. Once `ld_valid` drops or `ld_rd` changes, `i_instr_valid` rises in the same cycle (combinational).
- Execute sees a stable H while `i_instr_valid` & !`i_instr_ready`.
- Simultaneous events:
  - `flush` dominates accept, issue and `haz`.
  - Write-back matching an accepted beat is captured in that beat.
  - Write-back and hazard in the same cycle: forwarding still updates the stored operands.

## Structure
- Add to the shared `riscv` package:
  - `ex_entry_t` packed struct holding the entry fields.
  - `issue_state_t` enum {EMPTY, ONE, TWO}.
  - Reuse the existing `operation_t` for `t_op`/`i_op`.
- One sub-module, `issue_fwd_mux`: index compare plus value select for a single operand. Instantiate it for the operand paths.
- The state machine, entries and counter live in the top module.

## Test plan
- Back-to-back ADDs, `i_instr_ready`=1:
  - `i_instr_valid` one cycle after each accept.
  - `t_instr_ready` stays 1; 4 beats issue in 4 consecutive cycles.
- Hold `i_instr_ready`=0 and offer 3 beats:
  - 2 accepted; `t_instr_ready` drops after the second.
  - On release, beats issue in order with PCs 0x0, 0x4, then 0x8.
- Load-use: H has `rs1`=5 with `ld_valid`=1, `ld_rd`=5 for 2 cycles:
  - `i_instr_valid` low for 2 cycles; `stall_count`=2.
  - With `rd`=0 instead, no stall.
- Write-back `wb_rd`=3, `wb_value`=0xDEADBEEF while H and S both read x3 in `rs2` with stale value 0x1:
  - Both issue with `i_rs2Value`=0xDEADBEEF.
- `flush` asserted in state TWO with an upstream beat offered:
  - Next cycle EMPTY; none of the 3 instructions issue.
- Pull `rstf` low in state TWO:
  - Next cycle all outputs 0, `t_instr_ready`=0.
  - After release, `t_instr_ready`=1 and no stale issue.

Source files
------------

// File: rtl/exec_issue_ctrl_pkg.sv
// Shared types for the execute issue controller: operation codes, issue states
// and the buffered instruction entry.
package exec_issue_ctrl_pkg;

  localparam int ENTRY_XLEN = 32;

  typedef enum logic [4:0] {
    OP_ADD  = 5'd0,
    OP_SUB  = 5'd1,
    OP_AND  = 5'd2,
    OP_OR   = 5'd3,
    OP_XOR  = 5'd4,
    OP_LW   = 5'd5,
    OP_SW   = 5'd6,
    OP_BEQ  = 5'd7,
    OP_JAL  = 5'd8,
    OP_JALR = 5'd9
  } operation_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } issue_state_t;

  typedef struct packed {
    logic [31:0]           instr;
    logic [ENTRY_XLEN-1:0] pc;
    operation_t            op;
    logic [ENTRY_XLEN-1:0] imm;
    logic [4:0]            rs1;
    logic [4:0]            rs2;
    logic [ENTRY_XLEN-1:0] rs1Value;
    logic [ENTRY_XLEN-1:0] rs2Value;
  } ex_entry_t;

  // x0 is hardwired to zero, so it never aliases a load or a write-back
  function automatic logic reg_match(input logic [4:0] a, input logic [4:0] b);
    return (a != 5'd0) && (a == b);
  endfunction

endpackage

// File: rtl/exec_issue_ctrl_if.sv
// Decode-side and execute-side handshakes of the issue controller.
interface exec_issue_ctrl_if #(parameter int XLEN = 32);
  import exec_issue_ctrl_pkg::*;

  logic [31:0]     t_instr;
  logic            t_instr_valid;
  logic            t_instr_ready;
  logic [XLEN-1:0] t_pc;
  operation_t      t_op;
  logic [XLEN-1:0] t_imm;
  logic [4:0]      t_rs1;
  logic [4:0]      t_rs2;
  logic [XLEN-1:0] t_rs1Value;
  logic [XLEN-1:0] t_rs2Value;

  logic [31:0]     i_instr;
  logic            i_instr_valid;
  logic            i_instr_ready;
  logic [XLEN-1:0] i_pc;
  operation_t      i_op;
  logic [XLEN-1:0] i_imm;
  logic [XLEN-1:0] i_rs1Value;
  logic [XLEN-1:0] i_rs2Value;

  modport slave (
    input  t_instr, t_instr_valid, t_pc, t_op, t_imm, t_rs1, t_rs2, t_rs1Value, t_rs2Value,
    output t_instr_ready,
    output i_instr, i_instr_valid, i_pc, i_op, i_imm, i_rs1Value, i_rs2Value,
    input  i_instr_ready
  );

  modport master (
    output t_instr, t_instr_valid, t_pc, t_op, t_imm, t_rs1, t_rs2, t_rs1Value, t_rs2Value,
    input  t_instr_ready,
    input  i_instr, i_instr_valid, i_pc, i_op, i_imm, i_rs1Value, i_rs2Value,
    output i_instr_ready
  );

endinterface

// File: rtl/exec_issue_ctrl_fwd_mux.sv
// Single-operand write-back forward: replaces a stored value when write-back
// targets the same non-zero register.
module issue_fwd_mux
  import exec_issue_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [4:0]      rs_i,
  input  logic [XLEN-1:0] value_i,
  input  logic            wb_valid_i,
  input  logic [4:0]      wb_rd_i,
  input  logic [XLEN-1:0] wb_value_i,
  output logic [XLEN-1:0] value_o
);

  assign value_o = (wb_valid_i && reg_match(rs_i, wb_rd_i)) ? wb_value_i : value_i;

endmodule

// File: rtl/exec_issue_ctrl.sv
// Two-entry issue buffer between decode and execute with load-use stall,
// write-back operand refresh and branch flush.
module exec_issue_ctrl
  import exec_issue_ctrl_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rstf,
  exec_issue_ctrl_if.slave    bus,
  input  logic                ld_valid,
  input  logic [4:0]          ld_rd,
  input  logic                wb_valid,
  input  logic [4:0]          wb_rd,
  input  logic [XLEN-1:0]     wb_value,
  input  logic                flush,
  output logic [CNT_W-1:0]    stall_count
);

  issue_state_t     state_q;
  ex_entry_t        h_q, s_q, h_d, s_d;
  ex_entry_t        h_fwd, s_fwd, in_fwd;
  logic [CNT_W-1:0] stall_q;
  logic [XLEN-1:0]  h_rs1_v, h_rs2_v, s_rs1_v, s_rs2_v, in_rs1_v, in_rs2_v;
  logic             h_valid, haz, accept, issue;

  assign h_valid = (state_q != EMPTY);
  assign haz     = h_valid && ld_valid && (reg_match(h_q.rs1, ld_rd) || reg_match(h_q.rs2, ld_rd));
  assign accept  = bus.t_instr_valid && bus.t_instr_ready;
  assign issue   = bus.i_instr_valid && bus.i_instr_ready;

  assign bus.t_instr_ready = (state_q != TWO) && rstf;
  assign bus.i_instr_valid = h_valid && !haz && !flush;

  issue_fwd_mux #(.XLEN(XLEN)) u_fwd_h1 (.rs_i(h_q.rs1), .value_i(h_q.rs1Value), .wb_valid_i(wb_valid),
    .wb_rd_i(wb_rd), .wb_value_i(wb_value), .value_o(h_rs1_v));
  issue_fwd_mux #(.XLEN(XLEN)) u_fwd_h2 (.rs_i(h_q.rs2), .value_i(h_q.rs2Value), .wb_valid_i(wb_valid),
    .wb_rd_i(wb_rd), .wb_value_i(wb_value), .value_o(h_rs2_v));
  issue_fwd_mux #(.XLEN(XLEN)) u_fwd_s1 (.rs_i(s_q.rs1), .value_i(s_q.rs1Value), .wb_valid_i(wb_valid),
    .wb_rd_i(wb_rd), .wb_value_i(wb_value), .value_o(s_rs1_v));
  issue_fwd_mux #(.XLEN(XLEN)) u_fwd_s2 (.rs_i(s_q.rs2), .value_i(s_q.rs2Value), .wb_valid_i(wb_valid),
    .wb_rd_i(wb_rd), .wb_value_i(wb_value), .value_o(s_rs2_v));
  issue_fwd_mux #(.XLEN(XLEN)) u_fwd_t1 (.rs_i(bus.t_rs1), .value_i(bus.t_rs1Value), .wb_valid_i(wb_valid),
    .wb_rd_i(wb_rd), .wb_value_i(wb_value), .value_o(in_rs1_v));
  issue_fwd_mux #(.XLEN(XLEN)) u_fwd_t2 (.rs_i(bus.t_rs2), .value_i(bus.t_rs2Value), .wb_valid_i(wb_valid),
    .wb_rd_i(wb_rd), .wb_value_i(wb_value), .value_o(in_rs2_v));

  // Head fields are zeroed while empty so reset leaves execute a clean bus
  assign bus.i_instr    = h_valid ? h_q.instr : '0;
  assign bus.i_pc       = h_valid ? h_q.pc    : '0;
  assign bus.i_op       = h_valid ? h_q.op    : OP_ADD;
  assign bus.i_imm      = h_valid ? h_q.imm   : '0;
  assign bus.i_rs1Value = h_valid ? h_rs1_v   : '0;
  assign bus.i_rs2Value = h_valid ? h_rs2_v   : '0;
  assign stall_count    = stall_q;

  always_comb begin
    h_fwd = h_q;
    h_fwd.rs1Value = h_rs1_v;
    h_fwd.rs2Value = h_rs2_v;
    s_fwd = s_q;
    s_fwd.rs1Value = s_rs1_v;
    s_fwd.rs2Value = s_rs2_v;
    in_fwd = '{instr: bus.t_instr, pc: bus.t_pc, op: bus.t_op, imm: bus.t_imm,
               rs1: bus.t_rs1, rs2: bus.t_rs2, rs1Value: in_rs1_v, rs2Value: in_rs2_v};
    h_d = h_fwd;
    s_d = s_fwd;
    case (state_q)
      EMPTY:   if (accept) h_d = in_fwd;
      ONE: begin
        if (accept && issue) h_d = in_fwd;
        else if (accept)     s_d = in_fwd;
      end
      TWO:     if (issue) h_d = s_fwd;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstf) begin
      state_q <= EMPTY;
      stall_q <= '0;
    end else begin
      if (haz && !flush && (stall_q != '1)) stall_q <= stall_q + 1'b1;
      if (flush) begin
        state_q <= EMPTY;
      end else begin
        case (state_q)
          EMPTY:   if (accept) state_q <= ONE;
          ONE: begin
            if (issue && !accept)      state_q <= EMPTY;
            else if (accept && !issue) state_q <= TWO;
          end
          TWO:     if (issue) state_q <= ONE;
          default: state_q <= EMPTY;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    h_q <= h_d;
    s_q <= s_d;
  end

endmodule

// File: tb/tb_exec_issue_ctrl.sv
// Randomized and directed bench for exec_issue_ctrl against a queue-based model.
module tb_exec_issue_ctrl;
  import exec_issue_ctrl_pkg::*;

  localparam int XLEN  = 32;
  localparam int CNT_W = 4;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rstf, ld_valid, wb_valid, flush;
  logic [4:0]       ld_rd, wb_rd;
  logic [XLEN-1:0]  wb_value;
  logic [CNT_W-1:0] stall_count;

  exec_issue_ctrl_if #(.XLEN(XLEN)) bus();

  exec_issue_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rstf(rstf), .bus(bus), .ld_valid(ld_valid), .ld_rd(ld_rd),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_value(wb_value), .flush(flush),
    .stall_count(stall_count)
  );

  int n_chk = 0;
  int n_fail = 0;
  ex_entry_t mq[$];
  int m_stall = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit hit(input logic [4:0] a, input logic [4:0] b);
    return (a != 0) && (a == b);
  endfunction

  function automatic logic [XLEN-1:0] fwd(input logic [4:0] r, input logic [XLEN-1:0] v);
    return (wb_valid && hit(r, wb_rd)) ? wb_value : v;
  endfunction

  function automatic bit m_haz();
    if (mq.size() == 0 || !ld_valid) return 1'b0;
    return hit(mq[0].rs1, ld_rd) || hit(mq[0].rs2, ld_rd);
  endfunction

  function automatic bit m_ivalid();
    return (mq.size() > 0) && !m_haz() && !flush;
  endfunction

  task automatic check_outputs();
    chk("t_instr_ready", bus.t_instr_ready, (mq.size() < 2) && rstf);
    chk("i_instr_valid", bus.i_instr_valid, m_ivalid());
    chk("stall_count", stall_count, m_stall);
    if (mq.size() > 0) begin
      chk("i_pc", bus.i_pc, mq[0].pc);
      chk("i_instr", bus.i_instr, mq[0].instr);
      chk("i_op", bus.i_op, mq[0].op);
      chk("i_imm", bus.i_imm, mq[0].imm);
      chk("i_rs1Value", bus.i_rs1Value, fwd(mq[0].rs1, mq[0].rs1Value));
      chk("i_rs2Value", bus.i_rs2Value, fwd(mq[0].rs2, mq[0].rs2Value));
    end
  endtask

  // Advance the model across the coming clock edge using the current inputs
  task automatic model_update();
    ex_entry_t e;
    bit iss, acc;
    if (!rstf) begin
      mq.delete();
      m_stall = 0;
      return;
    end
    if (m_haz() && !flush && m_stall < MAXC) m_stall++;
    if (flush) begin
      mq.delete();
      return;
    end
    iss = m_ivalid() && bus.i_instr_ready;
    acc = bus.t_instr_valid && (mq.size() < 2);
    foreach (mq[k]) begin
      mq[k].rs1Value = fwd(mq[k].rs1, mq[k].rs1Value);
      mq[k].rs2Value = fwd(mq[k].rs2, mq[k].rs2Value);
    end
    if (iss) void'(mq.pop_front());
    if (acc) begin
      e = '{instr: bus.t_instr, pc: bus.t_pc, op: bus.t_op, imm: bus.t_imm, rs1: bus.t_rs1,
            rs2: bus.t_rs2, rs1Value: fwd(bus.t_rs1, bus.t_rs1Value),
            rs2Value: fwd(bus.t_rs2, bus.t_rs2Value)};
      mq.push_back(e);
    end
  endtask

  task automatic step();
    #1;
    check_outputs();
    model_update();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic offer(input logic [31:0] pc, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [31:0] v1, input logic [31:0] v2);
    bus.t_instr_valid = 1'b1;
    bus.t_instr       = {pc[15:0], 16'h0033};
    bus.t_pc          = pc;
    bus.t_op          = OP_ADD;
    bus.t_imm         = pc ^ 32'h5A5A_0000;
    bus.t_rs1         = r1;
    bus.t_rs2         = r2;
    bus.t_rs1Value    = v1;
    bus.t_rs2Value    = v2;
  endtask

  task automatic quiet();
    bus.t_instr_valid = 1'b0;
    ld_valid = 1'b0;
    wb_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic do_reset();
    rstf = 1'b0;
    step();
    rstf = 1'b1;
  endtask

  initial begin
    rstf = 1'b0;
    quiet();
    ld_rd = 0; wb_rd = 0; wb_value = 0;
    bus.i_instr_ready = 1'b0;
    offer(0, 0, 0, 0, 0);
    bus.t_instr_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("reset t_instr_ready", bus.t_instr_ready, 1'b0);
    chk("reset i_instr_valid", bus.i_instr_valid, 1'b0);
    chk("reset i_pc", bus.i_pc, 0);
    chk("reset stall_count", stall_count, 0);
    step();
    rstf = 1'b1;

    // back-to-back issue at full rate
    bus.i_instr_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      offer(4 * k, 1, 2, 32'h10 + k, 32'h20 + k);
      #1;
      chk("b2b t_instr_ready", bus.t_instr_ready, 1'b1);
      if (k > 0) begin
        chk("b2b i_instr_valid", bus.i_instr_valid, 1'b1);
        chk("b2b i_pc", bus.i_pc, 4 * (k - 1));
      end
      step();
    end
    bus.t_instr_valid = 1'b0;
    #1 chk("b2b last i_pc", bus.i_pc, 12);
    step();

    // back-pressure fills both entries, then drains in order
    bus.i_instr_ready = 1'b0;
    offer(32'h0, 1, 2, 1, 2); step();
    offer(32'h4, 1, 2, 1, 2); step();
    #1 chk("bp t_instr_ready full", bus.t_instr_ready, 1'b0);
    offer(32'h8, 1, 2, 1, 2); step();
    bus.i_instr_ready = 1'b1;
    #1 chk("bp issue0 pc", bus.i_pc, 32'h0);
    step();
    #1 chk("bp issue1 pc", bus.i_pc, 32'h4);
    step();
    bus.t_instr_valid = 1'b0;
    #1 chk("bp issue2 pc", bus.i_pc, 32'h8);
    step();

    // load-use stall for two cycles
    do_reset();
    ld_valid = 1'b1; ld_rd = 5;
    offer(32'h100, 5, 0, 7, 0); step();
    bus.t_instr_valid = 1'b0;
    #1 chk("ld stall c0 valid", bus.i_instr_valid, 1'b0);
    step();
    #1 chk("ld stall c1 valid", bus.i_instr_valid, 1'b0);
    step();
    ld_valid = 1'b0;
    #1 chk("ld release valid", bus.i_instr_valid, 1'b1);
    chk("ld stall_count", stall_count, 2);
    step();
    ld_valid = 1'b1; ld_rd = 0;
    offer(32'h104, 0, 0, 0, 0); step();
    bus.t_instr_valid = 1'b0;
    #1 chk("x0 no stall", bus.i_instr_valid, 1'b1);
    step();

    // stall counter saturates
    ld_rd = 6;
    offer(32'h108, 0, 6, 0, 0); step();
    bus.t_instr_valid = 1'b0;
    repeat (20) step();
    #1 chk("stall saturate", stall_count, MAXC);
    ld_valid = 1'b0;
    step();

    // write-back refreshes both buffered entries
    bus.i_instr_ready = 1'b0;
    offer(32'h40, 0, 3, 0, 1); step();
    offer(32'h44, 0, 3, 0, 1); step();
    bus.t_instr_valid = 1'b0;
    wb_valid = 1'b1; wb_rd = 3; wb_value = 32'hDEADBEEF;
    step();
    wb_valid = 1'b0;
    bus.i_instr_ready = 1'b1;
    #1 chk("wb head rs2", bus.i_rs2Value, 32'hDEADBEEF);
    step();
    #1 chk("wb skid rs2", bus.i_rs2Value, 32'hDEADBEEF);
    chk("wb skid pc", bus.i_pc, 32'h44);
    step();

    // flush in state TWO with a beat offered
    bus.i_instr_ready = 1'b0;
    offer(32'h80, 1, 1, 0, 0); step();
    offer(32'h84, 1, 1, 0, 0); step();
    offer(32'h88, 1, 1, 0, 0);
    bus.i_instr_ready = 1'b1;
    flush = 1'b1;
    #1 chk("flush cycle valid", bus.i_instr_valid, 1'b0);
    step();
    quiet();
    #1 chk("post flush valid", bus.i_instr_valid, 1'b0);
    chk("post flush ready", bus.t_instr_ready, 1'b1);
    step();
    step();

    // reset while holding two entries
    bus.i_instr_ready = 1'b0;
    offer(32'hC0, 1, 1, 0, 0); step();
    offer(32'hC4, 1, 1, 0, 0); step();
    bus.t_instr_valid = 1'b0;
    rstf = 1'b0;
    step();
    #1 chk("rst2 t_instr_ready", bus.t_instr_ready, 1'b0);
    chk("rst2 i_instr_valid", bus.i_instr_valid, 1'b0);
    chk("rst2 i_pc", bus.i_pc, 0);
    chk("rst2 i_rs1Value", bus.i_rs1Value, 0);
    rstf = 1'b1;
    bus.i_instr_ready = 1'b1;
    #1 chk("rst2 release ready", bus.t_instr_ready, 1'b1);
    chk("rst2 release valid", bus.i_instr_valid, 1'b0);
    step();

    // randomized traffic
    for (int c = 0; c < 2000; c++) begin
      bus.t_instr_valid = ($urandom_range(0, 9) < 7);
      bus.t_instr       = $urandom;
      bus.t_pc          = $urandom;
      bus.t_op          = operation_t'($urandom_range(0, 9));
      bus.t_imm         = $urandom;
      bus.t_rs1         = 5'($urandom_range(0, 7));
      bus.t_rs2         = 5'($urandom_range(0, 7));
      bus.t_rs1Value    = $urandom;
      bus.t_rs2Value    = $urandom;
      bus.i_instr_ready = ($urandom_range(0, 9) < 7);
      ld_valid          = ($urandom_range(0, 9) < 3);
      ld_rd             = 5'($urandom_range(0, 7));
      wb_valid          = ($urandom_range(0, 1) == 1);
      wb_rd             = 5'($urandom_range(0, 7));
      wb_value          = $urandom;
      flush             = ($urandom_range(0, 19) == 0);
      rstf              = ($urandom_range(0, 99) != 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
